ling_sum_pipe: RTL and testbench
================================

LING_SUM_PIPE -- requirements
Module: ling_sum_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width; only 64 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream has a carry-network result.
REQ-005 SHALL have port in_ready  output  1  block can accept the input this cycle.
REQ-006 SHALL have port cin  input  1  adder carry-in.
REQ-007 SHALL have port p  input  64  bitwise propagate (a^b).
REQ-008 SHALL have port g  input  64  bitwise generate (a&b).
REQ-009 SHALL have port h  input  64  Ling pseudo-carries h[64:1] from the 64-bit Ling carry network.
REQ-010 SHALL have port out_valid  output  1  sum/cout valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port sum  output  64  registered sum.
REQ-013 SHALL have port cout  output  1  registered carry-out.
REQ-014 SHALL have port ovf  output  1  registered signed overflow (present only under REQ-029).

Function
REQ-015 SHALL recover true carries: c[0]=cin; c[i]=h[i] & (p[i-1]|g[i-1]) for i=1..64.
REQ-016 SHALL compute sum[i]=p[i]^c[i] for i=0..63, and cout=c[64].
REQ-017 SHALL accept a transfer when in_valid && in_ready at a rising edge, and complete one when out_valid && out_ready.
REQ-018 SHALL have a latency of exactly 1 cycle from an accepted input to out_valid when the output register is empty or draining.
REQ-019 SHALL buffer results in a 2-entry skid buffer (main + skid registers) with states EMPTY, ONE, TWO.
REQ-020 SHALL use these transitions: EMPTY->ONE on accept; ONE->TWO on accept without drain; ONE->EMPTY on drain without accept; ONE->ONE on simultaneous accept and drain; TWO->ONE on drain (no accept possible).
REQ-021 SHALL drive in_ready registered: 1 in EMPTY and ONE, 0 in TWO; it SHALL NOT combinationally depend on out_ready.
REQ-022 SHALL output in order: in TWO, the main entry is presented first, and on drain the skid entry moves to main in the same edge.
REQ-023 SHALL hold sum, cout and ovf stable while out_valid && !out_ready.
REQ-024 SHALL sustain 1 result per cycle when out_ready is held high.
REQ-025 SHALL ignore p/g/h/cin values when in_valid=0.

Reset
REQ-026 SHALL, on rst_n low, asynchronously go to EMPTY with out_valid=0, in_ready=1, sum=0, cout=0, ovf=0.
REQ-027 SHALL discard any buffered results when reset is asserted mid-operation; no output transfer completes in the reset-release cycle unless a new input was accepted.

Configuration
REQ-028 SHALL compile ovf logic only when macro LING_SUM_OVF_EN is defined.
REQ-029 SHALL, with LING_SUM_OVF_EN defined, drive ovf=c[64]^c[63], registered and buffered alongside sum; without it, port ovf and its storage SHALL be absent.

Structure
REQ-030 SHALL place the WIDTH constant, the skid-state enum (EMPTY/ONE/TWO) and the result struct {sum, cout, ovf} in shared package ling_pkg.
REQ-031 SHALL implement REQ-015/016 (and the overflow term) in one combinational sub-module ling_sum_core; ling_sum_pipe holds only handshake and storage.

Verification
REQ-032 SHALL cover a single add of a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 (p,g,h from a golden Ling network) -> one cycle later sum=0, cout=1, ovf=0.
REQ-033 SHALL cover a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1 (macro on); port absent with macro off.
REQ-034 SHALL cover back-to-back 3 inputs with out_ready=0 -> in_ready drops after 2 accepts; after release, results emerge in input order.
REQ-035 SHALL cover out_ready=1 continuously with 1000 random inputs -> 1000 outputs, 1 per cycle, matching a+b+cin.
REQ-036 SHALL cover asserting rst_n=0 while in TWO -> out_valid=0, in_ready=1 immediately, with no buffered results emitted after release.
REQ-037 SHALL cover simultaneous accept and drain in ONE -> state stays ONE and the new result is presented on the next cycle.

Source files
------------

// File: rtl/ling_pkg.sv
// ---------------------------------------------------------------------------
// ling_pkg
// Shared definitions for the Ling-adder sum stage:
//   LING_WIDTH    - operand width (only 64 is supported)
//   skid_state_t  - occupancy of the two-entry output skid buffer
//   result_t      - one buffered result {sum, cout[, ovf]}
// Optional feature macro: LING_SUM_OVF_EN adds the signed-overflow bit to
// result_t. Without it, the bit and all of its storage are absent.
// ---------------------------------------------------------------------------
package ling_pkg;

  localparam int LING_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [LING_WIDTH-1:0] sum;
    logic                  cout;
`ifdef LING_SUM_OVF_EN
    logic                  ovf;
`endif
  } result_t;

  localparam result_t RESULT_ZERO = '0;

endpackage

// File: rtl/ling_sum_core.sv
// ---------------------------------------------------------------------------
// ling_sum_core
// Purely combinational back end of a Ling adder. Turns the Ling
// pseudo-carries back into true carries and forms sum / carry-out.
//   i_cin  - adder carry-in (true carry c[0])
//   i_p    - bitwise propagate a^b
//   i_g    - bitwise generate  a&b
//   i_h    - Ling pseudo-carries h[64:1]
//   o_res  - {sum, cout[, ovf]}
// Optional feature macro: LING_SUM_OVF_EN adds ovf = c[64]^c[63].
// ---------------------------------------------------------------------------
module ling_sum_core
  import ling_pkg::*;
(
  input  logic                  i_cin,
  input  logic [LING_WIDTH-1:0] i_p,
  input  logic [LING_WIDTH-1:0] i_g,
  input  logic [LING_WIDTH:1]   i_h,
  output result_t               o_res
);

  logic [LING_WIDTH:0]   w_c;
  logic [LING_WIDTH-1:0] w_t;

  // Transmit term t = a|b; since g implies p-or-g, p|g equals a|b.
  assign w_t = i_p | i_g;

  // Ling identity: c[i] = h[i] & t[i-1]. i_h is declared [64:1], so the
  // vector AND aligns h[i] with t[i-1] bit for bit.
  assign w_c[0]            = i_cin;
  assign w_c[LING_WIDTH:1] = i_h & w_t;

  always_comb begin
    o_res      = RESULT_ZERO;
    o_res.sum  = i_p ^ w_c[LING_WIDTH-1:0];
    o_res.cout = w_c[LING_WIDTH];
`ifdef LING_SUM_OVF_EN
    o_res.ovf  = w_c[LING_WIDTH] ^ w_c[LING_WIDTH-1];
`endif
  end

endmodule

// File: rtl/ling_sum_pipe.sv
// ---------------------------------------------------------------------------
// ling_sum_pipe
// Registered sum stage of a 64-bit Ling adder with valid/ready handshakes
// on both sides and a two-entry skid buffer, so in_ready is a flop and
// never depends combinationally on out_ready.
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - upstream handshake (carry-network result)
//   cin, p, g, h        - carry-in, propagate, generate, pseudo-carries
//   out_valid/out_ready - downstream handshake
//   sum, cout           - registered result
//   ovf                 - registered signed overflow (LING_SUM_OVF_EN only)
// Optional feature macro: LING_SUM_OVF_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_EMPTY | no result held; out_valid=0, in_ready=1
// ST_ONE   | r_main holds the presented result; in_ready=1
// ST_TWO   | r_main presented, r_skid holds the next result; in_ready=0
// ---------------------------------------------------------------------------
module ling_sum_pipe
  import ling_pkg::*;
#(
  parameter int WIDTH = LING_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             cin,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH:1]   h,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef LING_SUM_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  skid_state_t r_state;
  skid_state_t w_state_nxt;
  logic        r_in_ready;
  result_t     r_main;
  result_t     r_skid;
  result_t     w_res;

  logic w_accept;
  logic w_drain;
  logic w_load_main;
  logic w_load_skid;
  logic w_shift;

  ling_sum_core u_core (
    .i_cin (cin),
    .i_p   (p),
    .i_g   (g),
    .i_h   (h),
    .o_res (w_res)
  );

  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = r_in_ready;
  assign w_accept  = in_valid && r_in_ready;
  assign w_drain   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      // Registered ready: look ahead at the state we are entering.
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          // Presented result leaves while the new one takes its place.
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (w_drain) begin
          w_state_nxt = ST_ONE;
          w_shift     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Result storage only changes on load/shift, which keeps the presented
  // output stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= RESULT_ZERO;
      r_skid <= RESULT_ZERO;
    end else begin
      if (w_load_main) begin
        r_main <= w_res;
      end else if (w_shift) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_res;
      end
    end
  end

  assign sum  = r_main.sum;
  assign cout = r_main.cout;
`ifdef LING_SUM_OVF_EN
  assign ovf  = r_main.ovf;
`endif

endmodule

// File: tb/tb_ling_sum_pipe.sv
module tb_ling_sum_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        cin = 1'b0;
  logic [63:0] p = '0;
  logic [63:0] g = '0;
  logic [64:1] h = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] sum;
  logic        cout;
`ifdef LING_SUM_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ling_sum_pipe #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cin       (cin),
    .p         (p),
    .g         (g),
    .h         (h),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef LING_SUM_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic [63:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Golden Ling network: ripple true carries, then h[i] = g[i-1] | c[i-1].
  task automatic drive_add(input logic [63:0] a, input logic [63:0] b, input logic ci);
    logic [64:0] c;
    c[0] = ci;
    for (int i = 0; i < 64; i++) c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    p   = a ^ b;
    g   = a & b;
    cin = ci;
    for (int i = 1; i <= 64; i++) h[i] = g[i-1] | c[i-1];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string nm, input logic [63:0] s, input logic co, input logic ov);
    chk({nm, ".sum"}, sum, s);
    chk({nm, ".cout"}, {63'd0, cout}, {63'd0, co});
`ifdef LING_SUM_OVF_EN
    chk({nm, ".ovf"}, {63'd0, ovf}, {63'd0, ov});
`endif
  endtask

  logic [63:0] ra, rb;
  logic        rc;
  logic [64:0] rfull;
  logic [63:0] q_s[$];
  logic        q_c[$];
  logic        q_o[$];
  int          got;

  initial begin
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[4] = '{64'h1234, 64'h1, 1'b1, 64'h1236, 1'b0, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[7] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'h0, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
    chk_res("rst", 64'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // Table-driven single adds, one cycle latency, then drain
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive_add(vecs[i].a, vecs[i].b, vecs[i].ci);
      in_valid = 1'b1;
      step();
      chk($sformatf("vec%0d.out_valid", i), {63'd0, out_valid}, 64'd1);
      chk_res($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].ov);
      in_valid = 1'b0;
      drive_add(64'hDEAD_BEEF_0000_1111, 64'h1357_9BDF_2468_ACE0, 1'b1);
      step();
      chk($sformatf("vec%0d.drained", i), {63'd0, out_valid}, 64'd0);
    end

    // Backpressure: three back-to-back inputs with out_ready low
    out_ready = 1'b0;
    drive_add(64'd10, 64'd1, 1'b0);
    in_valid = 1'b1;
    step();
    chk("bp.ready_after1", {63'd0, in_ready}, 64'd1);
    drive_add(64'd20, 64'd2, 1'b0);
    step();
    chk("bp.ready_after2", {63'd0, in_ready}, 64'd0);
    chk("bp.valid", {63'd0, out_valid}, 64'd1);
    drive_add(64'd30, 64'd3, 1'b0);
    step();
    step();
    chk("bp.still_full", {63'd0, in_ready}, 64'd0);
    chk_res("bp.hold_A", 64'd11, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chk_res("bp.second_B", 64'd22, 1'b0, 1'b0);
    chk("bp.ready_back", {63'd0, in_ready}, 64'd1);
    step();
    chk_res("bp.third_C", 64'd33, 1'b0, 1'b0);
    chk("bp.valid_C", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    step();
    chk("bp.empty", {63'd0, out_valid}, 64'd0);

    // Simultaneous accept and drain in ONE
    drive_add(64'd100, 64'd5, 1'b0);
    in_valid = 1'b1;
    step();
    chk_res("ad.first", 64'd105, 1'b0, 1'b0);
    drive_add(64'd200, 64'd7, 1'b1);
    step();
    chk_res("ad.second", 64'd208, 1'b0, 1'b0);
    chk("ad.ready", {63'd0, in_ready}, 64'd1);
    chk("ad.valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    step();
    chk("ad.empty", {63'd0, out_valid}, 64'd0);

    // Reset while in TWO
    out_ready = 1'b0;
    drive_add(64'd1, 64'd1, 1'b0);
    in_valid = 1'b1;
    step();
    drive_add(64'd2, 64'd2, 1'b0);
    step();
    chk("rt.full", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rt.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rt.in_ready", {63'd0, in_ready}, 64'd1);
    chk_res("rt.cleared", 64'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rt.post%0d", k), {63'd0, out_valid}, 64'd0);
    end

    // 1000 random inputs at full throughput
    got = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      rfull = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
      q_s.push_back(rfull[63:0]);
      q_c.push_back(rfull[64]);
      q_o.push_back((ra[63] == rb[63]) && (rfull[63] != ra[63]));
      drive_add(ra, rb, rc);
      in_valid = 1'b1;
      step();
      chk("rnd.out_valid", {63'd0, out_valid}, 64'd1);
      chk("rnd.in_ready", {63'd0, in_ready}, 64'd1);
      if (out_valid && q_s.size() > 0) begin
        got++;
        chk_res($sformatf("rnd%0d", i), q_s.pop_front(), q_c.pop_front(), q_o.pop_front());
      end
    end
    in_valid = 1'b0;
    step();
    chk("rnd.count", 64'(got), 64'd1000);
    chk("rnd.empty", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
